// File: rtl/multiplexor_scan.sv
// Registered channel multiplexor with three modes: direct select, timed scan over
// enabled channels, and hold. Every output comes straight from a register.
module multiplexor_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 5,
  parameter int DWELL    = 4,
  localparam int AW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [AW-1:0]             addr,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       ch_mask,
  output logic [WIDTH-1:0]          out,
  output logic [AW-1:0]             out_ch,
  output logic                      valid,
  output logic                      err
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {S_DIRECT, S_SCAN, S_HOLD} state_t;

  state_t                           r_state, w_state;
  logic [WIDTH-1:0]                 r_out, w_out;
  logic [AW-1:0]                    r_ch, w_ch_nx;
  logic                             r_valid, w_valid;
  logic                             r_err, w_err;
  logic [CW-1:0]                    r_cnt, w_cnt;
  logic [CHANNELS-1:0][WIDTH-1:0]   w_ch;
  logic [AW-1:0]                    w_low, w_nxt, w_idx;
  logic                             w_any, w_found, w_legal, w_entry;

  assign w_ch    = in;
  assign w_legal = (int'(addr) < CHANNELS);

  // Lowest enabled channel, and next enabled channel above r_ch (circular).
  always_comb begin
    w_low   = '0;
    w_any   = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (ch_mask[AW'(k)]) begin
        w_low = AW'(k);
        w_any = 1'b1;
      end
    end
    w_nxt   = r_ch;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      w_idx = AW'((int'(r_ch) + k) % CHANNELS);
      if (!w_found && ch_mask[w_idx]) begin
        w_nxt   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // r_ch doubles as the scan pointer; valid=0 inside SCAN means "no channel
  // enabled yet", so the next scan edge is treated as a fresh entry.
  always_comb begin
    w_state = r_state;
    w_out   = r_out;
    w_ch_nx = r_ch;
    w_valid = r_valid;
    w_err   = 1'b0;
    w_cnt   = r_cnt;
    w_entry = (r_state != S_SCAN) || !r_valid;
    case (mode)
      2'b00: begin
        w_state = S_DIRECT;
        w_cnt   = '0;
        if (w_legal) begin
          w_out   = w_ch[addr];
          w_ch_nx = addr;
          w_valid = 1'b1;
        end else begin
          w_valid = 1'b0;
          w_err   = 1'b1;
        end
      end
      2'b01: begin
        w_state = S_SCAN;
        if (w_entry || r_cnt == CW'(DWELL - 1)) begin
          w_cnt = '0;
          if (!w_any) begin
            w_valid = 1'b0;
          end else begin
            w_ch_nx = w_entry ? w_low : w_nxt;
            w_out   = w_ch[w_ch_nx];
            w_valid = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
          w_out = w_ch[r_ch];
        end
      end
      default: w_state = S_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= S_DIRECT;
      r_out   <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_out   <= w_out;
      r_ch    <= w_ch_nx;
      r_valid <= w_valid;
      r_err   <= w_err;
      r_cnt   <= w_cnt;
    end
  end

  assign out    = r_out;
  assign out_ch = r_ch;
  assign valid  = r_valid;
  assign err    = r_err;
endmodule

// File: tb/tb_multiplexor_scan.sv
// Bench for multiplexor_scan: directed scenarios plus a randomized run, all
// outputs compared every cycle against a cycle-level behavioural model.
module tb_multiplexor_scan;
  localparam int W = 4, C = 5, D = 4, AW = 3;

  logic           clk = 1'b0;
  logic           clr;
  logic [C*W-1:0] in_d;
  logic [AW-1:0]  addr;
  logic [1:0]     mode;
  logic [C-1:0]   mask;
  logic [W-1:0]   out;
  logic [AW-1:0]  out_ch;
  logic           valid, err;

  logic [15:0]    in2;
  logic           addr2;
  logic [1:0]     mode2;
  logic [1:0]     mask2;
  logic [7:0]     out2;
  logic           och2;
  logic           valid2, err2;

  multiplexor_scan #(.WIDTH(W), .CHANNELS(C), .DWELL(D)) dut (
    .clk(clk), .clr(clr), .in(in_d), .addr(addr), .mode(mode), .ch_mask(mask),
    .out(out), .out_ch(out_ch), .valid(valid), .err(err));

  multiplexor_scan #(.WIDTH(8), .CHANNELS(2), .DWELL(1)) dut2 (
    .clk(clk), .clr(clr), .in(in2), .addr(addr2), .mode(mode2), .ch_mask(mask2),
    .out(out2), .out_ch(och2), .valid(valid2), .err(err2));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Channel values kept as an array; in_d is rebuilt from it on every change.
  logic [W-1:0] chv [C];

  task automatic pack();
    for (int k = 0; k < C; k++) in_d[k*W +: W] = chv[k];
  endtask

  task automatic put(input int k, input int v);
    chv[k] = W'(v);
    pack();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: prev mode, channel shown, how many cycles it has been shown.
  int         m_prev = 0, m_age = 0, m_ch = 0;
  bit         m_act = 0, m_valid = 0, m_err = 0, m_on = 0;
  logic [W-1:0] m_out = '0;

  function automatic int first_en(input int from);
    for (int j = 0; j < C; j++)
      if (mask[AW'((from + j) % C)]) return (from + j) % C;
    return -1;
  endfunction

  always @(posedge clk) begin
    int nx;
    m_on  = 1;
    m_err = 0;
    if (!clr) begin
      m_out = '0; m_ch = 0; m_valid = 0; m_prev = 0; m_act = 0; m_age = 0;
    end else begin
      case (mode)
        2'b00: begin
          m_prev = 0;
          if (addr < C) begin m_out = chv[addr]; m_ch = addr; m_valid = 1; end
          else begin m_valid = 0; m_err = 1; end
        end
        2'b01: begin
          if (m_prev != 1 || !m_act) begin nx = first_en(0); m_age = 1; end
          else if (m_age == D) begin nx = first_en(m_ch + 1); m_age = 1; end
          else begin nx = m_ch; m_age++; end
          if (nx < 0) begin m_valid = 0; m_act = 0; end
          else begin m_ch = nx; m_out = chv[nx]; m_valid = 1; m_act = 1; end
          m_prev = 1;
        end
        default: m_prev = 2;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("m_out", out, m_out);
      chk("m_ch", out_ch, m_ch);
      chk("m_valid", valid, m_valid);
      chk("m_err", err, m_err);
    end
  end

  initial begin
    clr = 1'b0; addr = '0; mode = 2'b00; mask = '0;
    for (int k = 0; k < C; k++) chv[k] = W'(k + 1);
    pack();
    in2 = 16'hB2A1; addr2 = 1'b0; mode2 = 2'b10; mask2 = 2'b11;

    // Reset
    step();
    chk("rst_out", out, 0); chk("rst_ch", out_ch, 0);
    chk("rst_valid", valid, 0); chk("rst_err", err, 0);
    clr = 1'b1;

    // Direct: legal then illegal address
    mode = 2'b00; addr = 3'd3; step();
    chk("dir_out", out, 4); chk("dir_ch", out_ch, 3);
    chk("dir_valid", valid, 1); chk("dir_err", err, 0);
    addr = 3'd6; step();
    chk("bad_out", out, 4); chk("bad_ch", out_ch, 3);
    chk("bad_valid", valid, 0); chk("bad_err", err, 1);
    mode = 2'b10; step();
    chk("err_pulse", err, 0); chk("hold_out", out, 4);

    // Scan all channels, with a live change on channel 1
    mask = 5'b11111; mode = 2'b01;
    for (int i = 0; i < 22; i++) begin
      step();
      chk("scan_ch", out_ch, (i / 4) % 5);
      if (i == 6) chk("live", out, 9);
      if (i == 5) put(1, 9);
    end

    // Sparse mask, then empty mask mid-dwell, then a single channel
    mode = 2'b00; addr = 3'd0; step();
    mask = 5'b10010; mode = 2'b01;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mask_ch", out_ch, ((i / 4) % 2) ? 4 : 1);
    end
    mask = 5'b00000;
    step(); chk("drain_ch", out_ch, 1); chk("drain_v", valid, 1);
    step(); chk("drain_ch", out_ch, 1); chk("drain_v", valid, 1);
    put(1, 7);
    step();
    chk("empty_v", valid, 0); chk("empty_ch", out_ch, 1); chk("empty_out", out, 9);
    mask = 5'b00100; step();
    chk("reent_ch", out_ch, 2); chk("reent_v", valid, 1); chk("reent_out", out, 3);

    // Hold mid-dwell, then restart at the lowest enabled channel
    step();
    mask = 5'b11111; mode = 2'b10; put(2, 12);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_out", out, 3); chk("hold_ch", out_ch, 2); chk("hold_v", valid, 1);
    end
    mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("restart_ch", out_ch, (i < 4) ? 0 : 1);
    end

    // Reset while scanning channel 3
    for (int i = 0; i < 40 && out_ch != 3'd3; i++) step();
    chk("reach_ch3", out_ch, 3);
    clr = 1'b0; step();
    chk("rs_out", out, 0); chk("rs_ch", out_ch, 0);
    chk("rs_valid", valid, 0); chk("rs_err", err, 0);
    clr = 1'b1; step();
    chk("rs_scan_ch", out_ch, 0); chk("rs_scan_v", valid, 1);

    // Small configuration: two channels, dwell of one
    mode2 = 2'b01;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("p_ch", och2, i % 2);
      chk("p_out", out2, (i % 2) ? 8'hB2 : 8'hA1);
    end
    mode2 = 2'b00; addr2 = 1'b1; step();
    chk("p_dir_err", err2, 0); chk("p_dir_ch", och2, 1);
    chk("p_dir_v", valid2, 1); chk("p_dir_out", out2, 8'hB2);
    mode2 = 2'b10;

    // Randomized run against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) < 6) begin
        int r = $urandom_range(0, 9);
        mode = (r < 2) ? 2'b00 : (r < 8) ? 2'b01 : 2'($urandom_range(2, 3));
      end
      if ($urandom_range(0, 99) < 4)
        mask = ($urandom_range(0, 4) == 0) ? '0 : C'($urandom);
      if ($urandom_range(0, 99) < 30) put($urandom_range(0, C - 1), $urandom_range(0, 15));
      addr = AW'($urandom_range(0, 7));
      clr  = ($urandom_range(0, 99) != 0);
      step();
    end
    clr = 1'b1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
